// File: rtl/block_fetch_pkg.sv
// Shared block-datapath definitions: matrix/tile geometry, element width,
// fetch FSM state encoding and a small index-width helper.
package block_fetch_pkg;

  localparam int BF_DATA_W = 32;  // element width in bits
  localparam int BF_J      = 2;   // tile rows
  localparam int BF_K      = 2;   // tile columns
  localparam int BF_A_M    = 4;   // source matrix rows
  localparam int BF_B_N    = 4;   // source matrix columns
  localparam int BF_ADDR_W = 16;  // source buffer word-address width
  localparam int BF_POS_W  = 10;  // width of start_row / start_col
  localparam int BF_SUM_W  = 16;  // row/col sums, wide enough that they never wrap

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_e;

  // Counter width for an index range 0..n-1, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/block_addr_gen.sv
// Maps a tile element position (start_row+i, start_col+j) onto a row-major
// source-buffer word address and flags whether it lies inside the matrix.
// Purely combinational; the fetch state lives in block_fetch.
module block_addr_gen
  import block_fetch_pkg::*;
#(
  parameter int M      = BF_A_M,
  parameter int N      = BF_B_N,
  parameter int ADDR_W = BF_ADDR_W,
  parameter int IW     = 1,
  parameter int JW     = 1
) (
  input  logic [BF_POS_W-1:0] start_row,
  input  logic [BF_POS_W-1:0] start_col,
  input  logic [IW-1:0]       i,
  input  logic [JW-1:0]       j,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                in_range
);

  logic [BF_SUM_W-1:0] row;
  logic [BF_SUM_W-1:0] col;

  // Sums are widened before the bounds test so a tile hanging off the
  // bottom/right edge is reported out of range instead of wrapping.
  always_comb begin
    row      = BF_SUM_W'(start_row) + BF_SUM_W'(i);
    col      = BF_SUM_W'(start_col) + BF_SUM_W'(j);
    in_range = (row < BF_SUM_W'(M)) && (col < BF_SUM_W'(N));
    mem_addr = ADDR_W'(32'(row) * 32'(N) + 32'(col));
  end

endmodule

// File: rtl/block_fetch.sv
// Fetches a J x K tile from an M x N row-major source buffer, one element
// per cycle, zero-padding elements that fall outside the matrix.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for start; tile holds the last result
//   READ     | issuing element c = 0..J*K-1, capturing element c-1
//   DRAIN    | capturing the last element's read data
//   DONE     | tile complete, done pulses for one cycle
module block_fetch
  import block_fetch_pkg::*;
#(
  parameter int DATA_W = BF_DATA_W,
  parameter int J      = BF_J,
  parameter int K      = BF_K,
  parameter int M      = BF_A_M,
  parameter int N      = BF_B_N,
  parameter int ADDR_W = BF_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BF_POS_W-1:0]     start_row,
  input  logic [BF_POS_W-1:0]     start_col,
  output logic                    mem_en,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic [DATA_W*J*K-1:0]   tile,
  output logic                    busy,
  output logic                    done
);

  localparam int NE = J * K;
  localparam int EW = idx_w(NE);
  localparam int IW = idx_w(J);
  localparam int JW = idx_w(K);

  localparam logic [EW-1:0] E_LAST = EW'(NE - 1);
  localparam logic [JW-1:0] J_LAST = JW'(K - 1);

  fetch_state_e state_q, state_d;
  logic                  load;

  logic [BF_POS_W-1:0]   row_q, col_q;
  logic [IW-1:0]         i_q;
  logic [JW-1:0]         j_q;
  logic [EW-1:0]         left_q;      // READ cycles remaining after this one

  logic                  cap_vld_q;
  logic                  cap_en_q;
  logic [EW-1:0]         cap_idx_q;
  logic [DATA_W*NE-1:0]  tile_q;

  logic [ADDR_W-1:0]     gen_addr;
  logic                  gen_in_range;

  block_addr_gen #(
    .M      (M),
    .N      (N),
    .ADDR_W (ADDR_W),
    .IW     (IW),
    .JW     (JW)
  ) u_addr_gen (
    .start_row (row_q),
    .start_col (col_q),
    .i         (i_q),
    .j         (j_q),
    .mem_addr  (gen_addr),
    .in_range  (gen_in_range)
  );

  // Next-state and status decode.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_READ;
          load    = 1'b1;
        end
      end
      ST_READ: begin
        busy = 1'b1;
        if (left_q == '0) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy    = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read request: only in-range elements touch the buffer; address is 0 otherwise.
  always_comb begin
    mem_en   = (state_q == ST_READ) && gen_in_range;
    mem_addr = mem_en ? gen_addr : '0;
  end

  // State register, element walk and one-cycle-delayed capture into the tile.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      i_q       <= '0;
      j_q       <= '0;
      left_q    <= '0;
      cap_vld_q <= 1'b0;
      cap_en_q  <= 1'b0;
      cap_idx_q <= '0;
      tile_q    <= '0;
    end else begin
      state_q <= state_d;

      if (load) begin
        row_q  <= start_row;
        col_q  <= start_col;
        i_q    <= '0;
        j_q    <= '0;
        left_q <= E_LAST;
      end else if (state_q == ST_READ) begin
        if (j_q == J_LAST) begin
          j_q <= '0;
          i_q <= i_q + 1'b1;
        end else begin
          j_q <= j_q + 1'b1;
        end
        if (left_q != '0) left_q <= left_q - 1'b1;
      end

      // The element issued this cycle returns data next cycle.
      cap_vld_q <= (state_q == ST_READ);
      cap_en_q  <= gen_in_range;
      cap_idx_q <= E_LAST - left_q;

      if (cap_vld_q) begin
        tile_q[int'(cap_idx_q)*DATA_W +: DATA_W] <= cap_en_q ? mem_rdata : '0;
      end
    end
  end

  assign tile = tile_q;

endmodule
